booth_pp_accum: RTL

Radix-4 Booth partial-product accumulator: the consuming end of the Booth encoder's partial-product interface. Accepts `LENGTH/2` signed partial products per multiplication over a valid/ready handshake, in order of increasing weight (4^0 first), then shifts, sign-extends and sums them into a `2*LENGTH`-bit signed product. It sits directly after the Booth encoder stage in the pipelined multiplier. It presents the product on a valid/ready output handshake.

---
 rtl/booth_pkg.sv | 14 +
 rtl/booth_pp_align.sv | 16 +
 rtl/booth_pp_accum.sv | 119 +++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared constants and state encoding for the radix-4 Booth multiplier stages.
package booth_pkg;

  localparam int LENGTH_DEF = 8;
  localparam int NUM_PP     = LENGTH_DEF / 2;
  localparam int CNT_W      = $clog2(NUM_PP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_pp_align.sv
// Sign-extends a Booth partial product to product width and shifts it to weight 4^k.
// Purely combinational; no handshake.
module booth_pp_align #(
  parameter int LENGTH = booth_pkg::LENGTH_DEF
) (
  input  logic [LENGTH+1:0]               pp_i,
  input  logic [$clog2(LENGTH/2)-1:0]     k_i,
  output logic [2*LENGTH-1:0]             term_o
);

  logic [2*LENGTH-1:0] ext;

  assign ext    = {{(LENGTH-2){pp_i[LENGTH+1]}}, pp_i};
  assign term_o = ext << {k_i, 1'b0};

endmodule

// File: rtl/booth_pp_accum.sv
// Accumulates LENGTH/2 Booth partial products (weight 4^0 first) into a signed product.
// One pp per cycle; product valid the cycle after the last accept; pp_ready drops while the product waits.
module booth_pp_accum
  import booth_pkg::*;
#(
  parameter int LENGTH = LENGTH_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  clear_i,
  input  logic [LENGTH+1:0]     pp_i,
  input  logic                  pp_valid_i,
  output logic                  pp_ready_o,
  output logic [2*LENGTH-1:0]   prod_o,
  output logic                  prod_valid_o,
  input  logic                  prod_ready_i,
  output logic                  busy_o
);

  localparam int PW  = 2 * LENGTH;
  localparam int NPP = LENGTH / 2;
  localparam int CW  = $clog2(NPP);
  localparam logic [CW-1:0] LAST_K = CW'(NPP - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            prod_vld_q, prod_vld_d;

  logic            accept;
  logic [PW-1:0]   term;
  logic [PW-1:0]   sum;

  // cnt_q is zero in IDLE, so the first term lands at weight 4^0.
  booth_pp_align #(.LENGTH(LENGTH)) u_align (
    .pp_i   (pp_i),
    .k_i    (cnt_q),
    .term_o (term)
  );

  assign sum          = acc_q + term;
  assign pp_ready_o   = (state_q != DONE);
  assign busy_o       = (state_q != IDLE);
  assign accept       = pp_valid_i && pp_ready_o;
  assign prod_o       = prod_q;
  assign prod_valid_o = prod_vld_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    prod_vld_d = prod_vld_q;

    if (clear_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      acc_d      = '0;
      prod_d     = '0;
      prod_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = sum;
            cnt_d   = CW'(1);
            state_d = ACC;
          end
        end
        ACC: begin
          if (accept) begin
            if (cnt_q == LAST_K) begin
              prod_d     = sum;
              prod_vld_d = 1'b1;
              acc_d      = '0;
              cnt_d      = '0;
              state_d    = DONE;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          if (prod_vld_q && prod_ready_i) begin
            prod_vld_d = 1'b0;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = IDLE;
          end
        end
        default: begin
          state_d    = IDLE;
          cnt_d      = '0;
          acc_d      = '0;
          prod_vld_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
    end
  end

endmodule
